// File: rtl/decode_issue_pkg.sv
// Shared opcode constants, field widths, FSM encoding and decoded-field record
// for the decode/issue stage.
package decode_issue_pkg;

  localparam int INSTR_W = 16;
  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 8;
  localparam int REG_W   = 4;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_HLT   = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_SUB   = 4'd3;
  localparam logic [3:0] OP_AND   = 4'd4;
  localparam logic [3:0] OP_OR    = 4'd5;
  localparam logic [3:0] OP_XOR   = 4'd6;
  localparam logic [3:0] OP_SHL   = 4'd7;
  localparam logic [3:0] OP_SHR   = 4'd8;
  localparam logic [3:0] OP_MOV   = 4'd9;
  localparam logic [3:0] OP_CMP   = 4'd10;
  localparam logic [3:0] OP_ILL11 = 4'd11;
  localparam logic [3:0] OP_ILL12 = 4'd12;
  localparam logic [3:0] OP_ILL13 = 4'd13;
  localparam logic [3:0] OP_LOAD  = 4'd14;
  localparam logic [3:0] OP_STORE = 4'd15;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_LDWAIT = 2'd1,
    ST_HALT   = 2'd2
  } state_e;

  typedef struct packed {
    logic [REG_W-1:0]  op;
    logic [REG_W-1:0]  dst;
    logic [REG_W-1:0]  src1;
    logic [REG_W-1:0]  src2;
    logic [ADDR_W-1:0] addr;
    logic              use1;
    logic              use2;
    logic              wr;
    logic              has_mem;
    logic              is_load;
    logic              is_stop;
  } dec_t;

endpackage

// File: rtl/decode_fields.sv
// Combinational split of an instruction word into fields plus operand-use,
// write-back and control classification.
module decode_fields
  import decode_issue_pkg::*;
(
  input  logic [INSTR_W-1:0] instr_i,
  output dec_t               dec_o
);

  logic [REG_W-1:0] op_s;
  logic [REG_W-1:0] d_s;
  logic [REG_W-1:0] a_s;
  logic [REG_W-1:0] b_s;

  assign op_s = instr_i[15:12];
  assign d_s  = instr_i[11:8];
  assign a_s  = instr_i[7:4];
  assign b_s  = instr_i[3:0];

  // Classify the opcode; STORE reads its data register from the d field.
  always_comb begin
    dec_o      = '0;
    dec_o.op   = op_s;
    dec_o.dst  = d_s;
    dec_o.src1 = a_s;
    dec_o.src2 = b_s;
    dec_o.addr = instr_i[7:0];
    case (op_s)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_CMP: begin
        dec_o.use1 = 1'b1;
        dec_o.use2 = 1'b1;
        dec_o.wr   = 1'b1;
      end
      OP_MOV: begin
        dec_o.use1 = 1'b1;
        dec_o.wr   = 1'b1;
      end
      OP_STORE: begin
        dec_o.src1    = d_s;
        dec_o.use1    = 1'b1;
        dec_o.has_mem = 1'b1;
      end
      OP_LOAD: begin
        dec_o.wr      = 1'b1;
        dec_o.has_mem = 1'b1;
        dec_o.is_load = 1'b1;
      end
      OP_HLT, OP_ILL11, OP_ILL12, OP_ILL13: begin
        dec_o.is_stop = 1'b1;
      end
      default: begin
        dec_o.wr = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/decode_issue.sv
// Decode/issue stage: RUN/LDWAIT/HALT control, registered issue to execute and
// back-to-back dependency tracking. Macro DECODE_FORWARD_EN selects forwarding
// flags instead of a one-cycle interlock.
module decode_issue
  import decode_issue_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instrValid,
  output logic               instrReq,
  output logic [REG_W-1:0]   regAddr1,
  output logic [REG_W-1:0]   regAddr2,
  input  logic [DATA_W-1:0]  regVal1,
  input  logic [DATA_W-1:0]  regVal2,
  input  logic               ldDone,
  output logic [REG_W-1:0]   opcode,
  output logic [REG_W-1:0]   destReg,
  output logic [DATA_W-1:0]  srcVal1,
  output logic [DATA_W-1:0]  srcVal2,
  output logic [ADDR_W-1:0]  memAddr,
  output logic               used1,
  output logic               used2,
  output logic               halted
);

  dec_t dec_s;

  decode_fields u_fields (
    .instr_i (instr),
    .dec_o   (dec_s)
  );

  state_e             state_q, state_d;
  logic [REG_W-1:0]   opcode_q, opcode_d;
  logic [REG_W-1:0]   dest_q, dest_d;
  logic [DATA_W-1:0]  src1_q, src1_d;
  logic [DATA_W-1:0]  src2_q, src2_d;
  logic [ADDR_W-1:0]  mem_q, mem_d;
  logic               used1_q, used1_d;
  logic               used2_q, used2_d;
  logic               halted_q, halted_d;
  logic [REG_W-1:0]   prev_dest_q, prev_dest_d;
  logic               prev_wr_q, prev_wr_d;

  logic hit1_s, hit2_s, fwd1_s, fwd2_s, hazard_s;

  assign regAddr1 = dec_s.use1 ? dec_s.src1 : 4'd0;
  assign regAddr2 = dec_s.use2 ? dec_s.src2 : 4'd0;

  assign hit1_s = dec_s.use1 & prev_wr_q & (dec_s.src1 == prev_dest_q);
  assign hit2_s = dec_s.use2 & prev_wr_q & (dec_s.src2 == prev_dest_q);

`ifdef DECODE_FORWARD_EN
  assign fwd1_s   = hit1_s;
  assign fwd2_s   = hit2_s;
  assign hazard_s = 1'b0;
`else
  // No bypass in execute: a dependent instruction waits one bubble instead.
  assign fwd1_s   = 1'b0;
  assign fwd2_s   = 1'b0;
  assign hazard_s = instrValid & (hit1_s | hit2_s);
`endif

  assign instrReq = (state_q == ST_RUN) & ~hazard_s;

  // Next state and next issue slot; every path not issuing leaves a bubble.
  always_comb begin
    state_d     = state_q;
    opcode_d    = 4'd0;
    dest_d      = 4'd0;
    src1_d      = 16'd0;
    src2_d      = 16'd0;
    mem_d       = 8'd0;
    used1_d     = 1'b0;
    used2_d     = 1'b0;
    halted_d    = halted_q;
    prev_dest_d = prev_dest_q;
    prev_wr_d   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (instrValid && !hazard_s) begin
          opcode_d    = dec_s.op;
          dest_d      = dec_s.wr ? dec_s.dst : 4'd0;
          src1_d      = dec_s.use1 ? regVal1 : 16'd0;
          src2_d      = dec_s.use2 ? regVal2 : 16'd0;
          mem_d       = dec_s.has_mem ? dec_s.addr : 8'd0;
          used1_d     = fwd1_s;
          used2_d     = fwd2_s;
          prev_wr_d   = dec_s.wr;
          prev_dest_d = dec_s.dst;
          if (dec_s.is_load) begin
            state_d = ST_LDWAIT;
          end else if (dec_s.is_stop) begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          prev_wr_d = 1'b0;
        end
      end
      ST_LDWAIT: begin
        // The load result is still the last write the next instruction sees.
        prev_wr_d = prev_wr_q;
        if (ldDone) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_LDWAIT;
        end
      end
      ST_HALT: begin
        state_d  = ST_HALT;
        halted_d = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State and issue registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      opcode_q    <= 4'd0;
      dest_q      <= 4'd0;
      src1_q      <= 16'd0;
      src2_q      <= 16'd0;
      mem_q       <= 8'd0;
      used1_q     <= 1'b0;
      used2_q     <= 1'b0;
      halted_q    <= 1'b0;
      prev_dest_q <= 4'd0;
      prev_wr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      opcode_q    <= opcode_d;
      dest_q      <= dest_d;
      src1_q      <= src1_d;
      src2_q      <= src2_d;
      mem_q       <= mem_d;
      used1_q     <= used1_d;
      used2_q     <= used2_d;
      halted_q    <= halted_d;
      prev_dest_q <= prev_dest_d;
      prev_wr_q   <= prev_wr_d;
    end
  end

  assign opcode  = opcode_q;
  assign destReg = dest_q;
  assign srcVal1 = src1_q;
  assign srcVal2 = src2_q;
  assign memAddr = mem_q;
  assign used1   = used1_q;
  assign used2   = used2_q;
  assign halted  = halted_q;

endmodule

// File: tb/tb_decode_issue.sv
// Scoreboard bench for decode_issue; expectations follow DECODE_FORWARD_EN.
module tb_decode_issue;

`ifdef DECODE_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct packed {
    logic [3:0]  op;
    logic [3:0]  dst;
    logic [15:0] s1;
    logic [15:0] s2;
    logic [7:0]  mem;
    logic        u1;
    logic        u2;
    logic        h;
    logic        req;
  } out_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr;
  logic        instrValid;
  logic        instrReq;
  logic [3:0]  regAddr1, regAddr2;
  logic [15:0] regVal1, regVal2;
  logic        ldDone;
  logic [3:0]  opcode, destReg;
  logic [15:0] srcVal1, srcVal2;
  logic [7:0]  memAddr;
  logic        used1, used2, halted;

  out_t exp_q[$];
  out_t obs_q[$];
  int   total  = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  decode_issue dut (
    .clk        (clk),
    .rst        (rst),
    .instr      (instr),
    .instrValid (instrValid),
    .instrReq   (instrReq),
    .regAddr1   (regAddr1),
    .regAddr2   (regAddr2),
    .regVal1    (regVal1),
    .regVal2    (regVal2),
    .ldDone     (ldDone),
    .opcode     (opcode),
    .destReg    (destReg),
    .srcVal1    (srcVal1),
    .srcVal2    (srcVal2),
    .memAddr    (memAddr),
    .used1      (used1),
    .used2      (used2),
    .halted     (halted)
  );

  // Register file contents: r1 = 5, r2 = 7, rN = 0xNNNN otherwise.
  function automatic logic [15:0] rfv(input logic [3:0] r);
    if (r == 4'd1) return 16'd5;
    if (r == 4'd2) return 16'd7;
    return {r, r, r, r};
  endfunction

  assign regVal1 = rfv(regAddr1);
  assign regVal2 = rfv(regAddr2);

  function automatic out_t mk(input logic [3:0] op, input logic [3:0] dst,
                              input logic [15:0] s1, input logic [15:0] s2,
                              input logic [7:0] mem, input logic u1, input logic u2,
                              input logic h, input logic req);
    return {op, dst, s1, s2, mem, u1, u2, h, req};
  endfunction

  function automatic out_t bub(input logic h, input logic req);
    return {4'd0, 4'd0, 16'd0, 16'd0, 8'd0, 1'b0, 1'b0, h, req};
  endfunction

  // One clock: present inputs, record expectation and the observed slot.
  task automatic cycle(input logic [15:0] ins, input logic v, input logic ld, input out_t e);
    out_t o;
    instr = ins;
    instrValid = v;
    ldDone = ld;
    exp_q.push_back(e);
    #1;
    o.req = instrReq;
    @(posedge clk);
    #1;
    o.op = opcode;  o.dst = destReg; o.s1 = srcVal1; o.s2 = srcVal2;
    o.mem = memAddr; o.u1 = used1;   o.u2 = used2;   o.h = halted;
    obs_q.push_back(o);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    logic [50:0] snap;
    rst = 1'b1; instr = 16'h2312; instrValid = 1'b1; ldDone = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    snap = {opcode, destReg, srcVal1, srcVal2, memAddr, used1, used2, halted};
    total++;
    if (snap !== 51'd0) $display("FAIL reset_outputs: got %h want 0", snap);
    else passed++;
    rst = 1'b0;
    #1;
    total++;
    if (instrReq !== 1'b1) $display("FAIL reset_instrReq: got %b want 1", instrReq);
    else passed++;
  endtask

  task automatic test_add();
    out_t e, o;
    int n = 0;
    cycle(16'h2312, 1'b1, 1'b0, mk(4'd2, 4'd3, 16'd5, 16'd7, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1));
    cycle(16'h0000, 1'b0, 1'b0, bub(1'b0, 1'b1));
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) $display("FAIL add[%0d]: got %h want %h", n, o, e);
      else passed++;
      n++;
    end
  endtask

  task automatic test_back_to_back();
    out_t e, o;
    int n = 0;
    cycle(16'h2312, 1'b1, 1'b0, mk(4'd2, 4'd3, 16'd5, 16'd7, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1));
    if (!FWD) cycle(16'h3433, 1'b1, 1'b0, bub(1'b0, 1'b0));
    cycle(16'h3433, 1'b1, 1'b0, mk(4'd3, 4'd4, 16'h3333, 16'h3333, 8'h00, FWD, FWD, 1'b0, 1'b1));
    cycle(16'h0000, 1'b0, 1'b0, bub(1'b0, 1'b1));
    cycle(16'h2312, 1'b1, 1'b0, mk(4'd2, 4'd3, 16'd5, 16'd7, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1));
    cycle(16'h0000, 1'b0, 1'b0, bub(1'b0, 1'b1));
    cycle(16'h3433, 1'b1, 1'b0, mk(4'd3, 4'd4, 16'h3333, 16'h3333, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1));
    cycle(16'h0000, 1'b0, 1'b0, bub(1'b0, 1'b1));
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) $display("FAIL back_to_back[%0d]: got %h want %h", n, o, e);
      else passed++;
      n++;
    end
  endtask

  task automatic test_load();
    out_t e, o;
    int n = 0;
    cycle(16'hE62A, 1'b1, 1'b0, mk(4'd14, 4'd6, 16'd0, 16'd0, 8'h2A, 1'b0, 1'b0, 1'b0, 1'b1));
    cycle(16'h2761, 1'b1, 1'b0, bub(1'b0, 1'b0));
    cycle(16'h2761, 1'b1, 1'b0, bub(1'b0, 1'b0));
    cycle(16'h2761, 1'b1, 1'b1, bub(1'b0, 1'b0));
    if (!FWD) cycle(16'h2761, 1'b1, 1'b0, bub(1'b0, 1'b0));
    cycle(16'h2761, 1'b1, 1'b0, mk(4'd2, 4'd7, 16'h6666, 16'd5, 8'h00, FWD, 1'b0, 1'b0, 1'b1));
    cycle(16'h0000, 1'b0, 1'b1, bub(1'b0, 1'b1));
    cycle(16'hF533, 1'b1, 1'b0, mk(4'd15, 4'd0, 16'h5555, 16'd0, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1));
    cycle(16'h0000, 1'b0, 1'b0, bub(1'b0, 1'b1));
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) $display("FAIL load[%0d]: got %h want %h", n, o, e);
      else passed++;
      n++;
    end
  endtask

  task automatic test_halt();
    out_t e, o;
    int n = 0;
    cycle(16'h1234, 1'b1, 1'b0, mk(4'd1, 4'd0, 16'd0, 16'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1));
    cycle(16'h2312, 1'b1, 1'b0, bub(1'b1, 1'b0));
    cycle(16'h2312, 1'b1, 1'b1, bub(1'b1, 1'b0));
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) $display("FAIL halt[%0d]: got %h want %h", n, o, e);
      else passed++;
      n++;
    end
    rst = 1'b1;
    #1;
    total++;
    if (halted !== 1'b0) $display("FAIL halt_reset: got halted %b want 0", halted);
    else passed++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    total++;
    if (instrReq !== 1'b1) $display("FAIL halt_release: got instrReq %b want 1", instrReq);
    else passed++;
  endtask

  task automatic test_illegal();
    out_t e, o;
    logic [51:0] snap;
    int n = 0;
    cycle(16'hC345, 1'b1, 1'b0, mk(4'd12, 4'd0, 16'd0, 16'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1));
    cycle(16'h2312, 1'b1, 1'b0, bub(1'b1, 1'b0));
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) $display("FAIL illegal[%0d]: got %h want %h", n, o, e);
      else passed++;
      n++;
    end
    pulse_reset();
    cycle(16'hE12A, 1'b1, 1'b0, mk(4'd14, 4'd1, 16'd0, 16'd0, 8'h2A, 1'b0, 1'b0, 1'b0, 1'b1));
    e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
    if (o !== e) $display("FAIL illegal_load: got %h want %h", o, e);
    else passed++;
    total++;
    if (instrReq !== 1'b0) $display("FAIL ldwait_req: got %b want 0", instrReq);
    else passed++;
    rst = 1'b1;
    #1;
    snap = {opcode, destReg, srcVal1, srcVal2, memAddr, used1, used2, halted, instrReq};
    total++;
    if (snap !== 52'd1) $display("FAIL ldwait_reset: got %h want 1", snap);
    else passed++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle(16'h2366, 1'b1, 1'b0, mk(4'd2, 4'd3, 16'h6666, 16'h6666, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1));
    cycle(16'h0000, 1'b0, 1'b0, bub(1'b0, 1'b1));
    n = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) $display("FAIL after_reset[%0d]: got %h want %h", n, o, e);
      else passed++;
      n++;
    end
  endtask

  task automatic test_dependency();
    out_t e, o;
    int n = 0;
    cycle(16'h2312, 1'b1, 1'b0, mk(4'd2, 4'd3, 16'd5, 16'd7, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1));
    if (!FWD) cycle(16'h4532, 1'b1, 1'b0, bub(1'b0, 1'b0));
    cycle(16'h4532, 1'b1, 1'b0, mk(4'd4, 4'd5, 16'h3333, 16'd7, 8'h00, FWD, 1'b0, 1'b0, 1'b1));
    if (!FWD) cycle(16'h6815, 1'b1, 1'b0, bub(1'b0, 1'b0));
    cycle(16'h6815, 1'b1, 1'b0, mk(4'd6, 4'd8, 16'd5, 16'h5555, 8'h00, 1'b0, FWD, 1'b0, 1'b1));
    if (!FWD) cycle(16'h9988, 1'b1, 1'b0, bub(1'b0, 1'b0));
    cycle(16'h9988, 1'b1, 1'b0, mk(4'd9, 4'd9, 16'h8888, 16'd0, 8'h00, FWD, 1'b0, 1'b0, 1'b1));
    cycle(16'h0000, 1'b0, 1'b0, bub(1'b0, 1'b1));
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) $display("FAIL dependency[%0d]: got %h want %h", n, o, e);
      else passed++;
      n++;
    end
  endtask

  initial begin
    rst = 1'b1;
    instr = 16'h0000;
    instrValid = 1'b0;
    ldDone = 1'b0;
    test_reset();
    test_add();
    test_back_to_back();
    test_load();
    test_halt();
    test_illegal();
    test_dependency();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/decode_issue.md
DECODE_ISSUE -- requirements
Module: decode_issue

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single rising-edge clock.
REQ-002 The block SHALL have the port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have the port instr, input, 16 bits: the instruction word from fetch.
REQ-004 The block SHALL have the port instrValid, input, 1 bit: instr is valid this cycle.
REQ-005 The block SHALL have the port instrReq, output, 1 bit: decode accepts an instruction at the next edge.
REQ-006 The block SHALL have the ports regAddr1 and regAddr2, output, 4 bits each: combinational register-file read addresses.
REQ-007 The block SHALL have the ports regVal1 and regVal2, input, 16 bits each: register-file read data.
REQ-008 The block SHALL have the port ldDone, input, 1 bit: a one-cycle pulse when the load value has been written back.
REQ-009 The block SHALL have the following registered outputs to execute: opcode[3:0], destReg[3:0], srcVal1[15:0], srcVal2[15:0], memAddr[7:0], used1 and used2.
REQ-010 The block SHALL have the port halted, output, 1 bit: decode has stopped after HLT or an illegal opcode.

Function
REQ-011 Instruction fields SHALL be decoded as op = instr[15:12], d = instr[11:8], a = instr[7:4], b = instr[3:0] and addr = instr[7:0].
REQ-012 Operands SHALL be selected as follows:
- ALU ops 2-8 and 10: regAddr1 = a and regAddr2 = b.
- Op 9: regAddr1 = a; the second operand is unused.
- Op 15 (STORE): regAddr1 = d; the second operand is unused.
- Ops 0, 1 and 14: no operand is used.
REQ-013 Unused operands SHALL drive srcVal = 0 and used = 0; memAddr SHALL equal addr for ops 14/15 and be 0 otherwise; destReg SHALL equal d for ops 2-10/14 and be 0 otherwise.
REQ-014 The FSM states SHALL be RUN, LDWAIT and HALT.
REQ-015 In RUN, instrReq SHALL be 1; at each edge with instrValid = 1, decode SHALL issue the instruction, with outputs updated at that edge for execute to sample at the next edge (latency: 1 cycle).
REQ-016 In RUN, at an edge with instrValid = 0, decode SHALL issue a bubble: all execute outputs 0 (NOP).
REQ-017 Issuing op 14 (LOAD) SHALL move the FSM to LDWAIT.
REQ-018 In LDWAIT, instrReq SHALL be 0, bubbles SHALL be issued, and the FSM SHALL return to RUN at the edge where ldDone = 1.
REQ-019 Issuing op 1 (HLT) or ops 11-13 (illegal) SHALL issue that opcode once, then enter HALT.
REQ-020 In HALT, halted and instrReq SHALL be 1 and 0 respectively, bubbles SHALL be issued, and only rst exits the state.
REQ-021 Decode SHALL record prevDest and prevWr, where prevWr = 1 iff the immediately preceding issued slot was op 2-10 or op 14.
REQ-022 A bubble SHALL clear prevWr.
REQ-023 The first instruction issued after LDWAIT SHALL see prevWr = 1 with prevDest = the load destination.
REQ-024 used1 SHALL equal (operand 1 used) AND prevWr AND (source 1 == prevDest); used2 SHALL follow the same rule for source 2, and both may be 1 simultaneously.
REQ-025 ldDone in RUN or HALT SHALL be ignored.

Reset
REQ-026 While rst = 1, all execute outputs SHALL be 0, halted SHALL be 0, prevWr SHALL be 0, and the FSM SHALL be in RUN.
REQ-027 On rst deassertion, instrReq SHALL be 1.
REQ-028 Reset SHALL take effect immediately in any state, including mid-LDWAIT, with no ldDone required.

Configuration
REQ-029 With macro DECODE_FORWARD_EN defined, used1 and used2 SHALL behave per REQ-024.
REQ-030 Without DECODE_FORWARD_EN, used1 and used2 SHALL be tied to 0, and any instruction whose used source matches prevDest with prevWr = 1 SHALL be held: one bubble is issued, instrReq = 0 for that cycle, and the instruction is reissued on the following cycle.

Structure
REQ-031 A shared package SHALL define the opcode constants (OP_NOP = 0 ... OP_STORE = 15), the field widths (16/8/4), and the FSM state encoding.
REQ-032 One sub-module, decode_fields, SHALL perform the combinational field and operand-use extraction; the FSM and forwarding logic SHALL live in decode_issue.

Verification
REQ-033 Issue ADD r3 = r1 + r2 with r1 = 5 and r2 = 7 -> after 1 edge: opcode = 2, destReg = 3, srcVal1 = 5, srcVal2 = 7, used1 = used2 = 0.
REQ-034 Issue ADD r3,r1,r2 then SUB r4,r3,r3 back-to-back (forwarding enabled) -> the second issue has used1 = used2 = 1; with a bubble between them, both are 0.
REQ-035 Issue LOAD r6,0x2A then ADD r7,r6,r1 -> memAddr = 0x2A and instrReq = 0 until ldDone; the ADD then issues with used1 = 1 and used2 = 0.
REQ-036 Issue HLT, then hold instrValid = 1 -> opcode = 1 once, then halted = 1, instrReq = 0 and NOPs; asserting rst clears halted.
REQ-037 Issue opcode 12 -> enters HALT; rst asserted in LDWAIT -> RUN with outputs 0 immediately.
REQ-038 Without forwarding, issue ADD r3,r1,r2 then AND r5,r3,r2 -> one bubble, then the AND issues with used1 = 0 and srcVal1 = the register-file r3.
